// File: rtl/ifq_fetch_ctrl.sv
// Fetch controller for the IFQ FIFO: walks line-aligned fetch addresses through the
// I-cache, pushes returned lines, parks a line while the FIFO is full, and redirects.
module ifq_fetch_ctrl #(
  parameter int                    CACHE_LINE_WIDTH = 128,
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        jmp_branch_valid,
  input  logic [ADDR_WIDTH-1:0]       jmp_branch_address,
  input  logic [CACHE_LINE_WIDTH-1:0] icache_rd_data,
  input  logic                        icache_ready,
  input  logic                        fifo_full,
  output logic                        icache_rd_en,
  output logic [ADDR_WIDTH-1:0]       icache_addr,
  output logic                        fifo_write_en,
  output logic                        flush,
  output logic [1:0]                  Jmp_Branch_Bits_2_3,
  output logic [CACHE_LINE_WIDTH-1:0] Data_out
);

  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(16);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc_line, pc_line_nxt;
  logic [ADDR_WIDTH-1:0]   target_line, target_line_nxt;
  logic [1:0]              jmp_off, jmp_off_nxt;
  logic [CACHE_LINE_WIDTH-1:0] hold_line, hold_line_nxt;

  // Byte-within-word bits of the redirect target carry no meaning for fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^jmp_branch_address[1:0];

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:4], 4'h0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_line     <= line_align(RESET_PC);
      target_line <= '0;
      jmp_off     <= 2'b00;
      hold_line   <= '0;
    end else begin
      state       <= state_nxt;
      pc_line     <= pc_line_nxt;
      target_line <= target_line_nxt;
      jmp_off     <= jmp_off_nxt;
      hold_line   <= hold_line_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    pc_line_nxt         = pc_line;
    target_line_nxt     = target_line;
    jmp_off_nxt         = jmp_off;
    hold_line_nxt       = hold_line;
    icache_rd_en        = 1'b0;
    icache_addr         = '0;
    fifo_write_en       = 1'b0;
    flush               = 1'b0;
    Jmp_Branch_Bits_2_3 = 2'b00;
    Data_out            = '0;

    unique case (state)
      IDLE: begin
        state_nxt = REQ;
      end

      REQ: begin
        icache_rd_en = 1'b1;
        icache_addr  = pc_line;
        Data_out     = icache_rd_data;
        if (icache_ready) begin
          if (!fifo_full) begin
            fifo_write_en = 1'b1;
            pc_line_nxt   = pc_line + LINE_BYTES;
          end else begin
            hold_line_nxt = icache_rd_data;
            state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        Data_out = hold_line;
        if (!fifo_full) begin
          fifo_write_en = 1'b1;
          pc_line_nxt   = pc_line + LINE_BYTES;
          state_nxt     = REQ;
        end
      end

      REDIR: begin
        icache_rd_en = 1'b1;
        icache_addr  = target_line;
        Data_out     = icache_rd_data;
        // The target line becomes the first FIFO entry regardless of fifo_full.
        if (icache_ready) begin
          flush               = 1'b1;
          Jmp_Branch_Bits_2_3 = jmp_off;
          pc_line_nxt         = target_line + LINE_BYTES;
          state_nxt           = REQ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A redirect wins over everything above: the wrong-path line is dropped and any
    // parked line or older target is forgotten.
    if (jmp_branch_valid) begin
      fifo_write_en       = 1'b0;
      flush               = 1'b0;
      Jmp_Branch_Bits_2_3 = 2'b00;
      pc_line_nxt         = pc_line;
      hold_line_nxt       = hold_line;
      target_line_nxt     = line_align(jmp_branch_address);
      jmp_off_nxt         = jmp_branch_address[3:2];
      state_nxt           = REDIR;
    end
  end

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Bench for ifq_fetch_ctrl: directed scenarios then random traffic, checked by a
// scoreboard that predicts the ordered stream of FIFO pushes/flushes.
module tb_ifq_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         jmp_branch_valid;
  logic [31:0]  jmp_branch_address;
  logic [127:0] icache_rd_data;
  logic         icache_ready;
  logic         fifo_full;
  logic         icache_rd_en;
  logic [31:0]  icache_addr;
  logic         fifo_write_en;
  logic         flush;
  logic [1:0]   Jmp_Branch_Bits_2_3;
  logic [127:0] Data_out;

  ifq_fetch_ctrl #(
    .CACHE_LINE_WIDTH(128),
    .ADDR_WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jmp_branch_valid(jmp_branch_valid),
    .jmp_branch_address(jmp_branch_address),
    .icache_rd_data(icache_rd_data),
    .icache_ready(icache_ready),
    .fifo_full(fifo_full),
    .icache_rd_en(icache_rd_en),
    .icache_addr(icache_addr),
    .fifo_write_en(fifo_write_en),
    .flush(flush),
    .Jmp_Branch_Bits_2_3(Jmp_Branch_Bits_2_3),
    .Data_out(Data_out)
  );

  always #5 clk = ~clk;

  // Expected FIFO event: a plain push of line addr, or a flush of line addr with offset.
  typedef struct packed {
    logic        fl;
    logic [31:0] addr;
    logic [1:0]  off;
  } exp_t;

  exp_t         q[$];
  bit           holding;
  bit           first_cyc;
  logic [127:0] junk;
  int           n_cmp = 0;
  int           n_bad = 0;

  // Content the cache model returns for a given line address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
  endfunction

  always_comb begin
    icache_rd_data = junk;
    if (icache_ready) icache_rd_data = line_of(icache_addr);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one pass per cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t h;
    bit   e_rd, e_wr, e_fl;
    h    = '0;
    e_rd = 1'b0;
    e_wr = 1'b0;
    e_fl = 1'b0;
    if (rst) begin
      check("reset_ctrl", {92'd0, icache_rd_en, icache_addr, fifo_write_en, flush, Jmp_Branch_Bits_2_3}, '0);
      check("reset_data", Data_out, '0);
    end else if (first_cyc) begin
      first_cyc = 1'b0;
      check("idle_ctrl", {92'd0, icache_rd_en, icache_addr, fifo_write_en, flush, Jmp_Branch_Bits_2_3}, '0);
    end else if (q.size() == 0) begin
      check("model_nonempty", 128'd0, 128'd1);
    end else begin
      h    = q[0];
      e_rd = !holding;
      if (jmp_branch_valid) begin
        e_wr = 1'b0;
        e_fl = 1'b0;
      end else if (holding) begin
        e_wr = !fifo_full;
      end else if (h.fl) begin
        e_fl = icache_ready;
      end else begin
        e_wr = icache_ready && !fifo_full;
      end
      check("icache_rd_en", 128'(icache_rd_en), 128'(e_rd));
      check("fifo_write_en", 128'(fifo_write_en), 128'(e_wr));
      check("flush", 128'(flush), 128'(e_fl));
      if (e_rd && !jmp_branch_valid) check("icache_addr", 128'(icache_addr), 128'(h.addr));
      if (fifo_write_en || flush) check("data_out", Data_out, line_of(h.addr));
      if (flush) check("jmp_bits_2_3", 128'(Jmp_Branch_Bits_2_3), 128'(h.off));
      if (e_wr || e_fl) begin
        void'(q.pop_front());
        q.push_back({1'b0, h.addr + 32'd16, 2'b00});
      end
      if (jmp_branch_valid) holding = 1'b0;
      else if (holding) holding = fifo_full;
      else holding = !h.fl && icache_ready && fifo_full;
    end
  end

  task automatic cyc(input bit rdy, input bit ful, input bit j, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    junk               = {$urandom, $urandom, $urandom, $urandom};
    icache_ready       = rdy;
    fifo_full          = ful;
    jmp_branch_valid   = j;
    jmp_branch_address = tgt;
    if (j) begin
      q.delete();
      q.push_back({1'b1, tgt[31:4], 4'h0, tgt[3:2]});
    end
  endtask

  // Asynchronous assert mid-cycle; outputs must drop without waiting for an edge.
  task automatic reset_assert();
    @(posedge clk);
    #2;
    rst              = 1'b1;
    jmp_branch_valid = 1'b0;
    #1;
    check("rst_async_ctrl", {92'd0, icache_rd_en, icache_addr, fifo_write_en, flush, Jmp_Branch_Bits_2_3}, '0);
    check("rst_async_data", Data_out, '0);
    q.delete();
    holding = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    icache_ready     = 1'b1;
    fifo_full        = 1'b0;
    jmp_branch_valid = 1'b0;
    rst              = 1'b0;
    first_cyc        = 1'b1;
    q.push_back({1'b1 ^ 1'b1, 32'h0000_0000, 2'b00});
  endtask

  initial begin
    logic [31:0] tgt;
    rst                = 1'b1;
    jmp_branch_valid   = 1'b0;
    jmp_branch_address = '0;
    icache_ready       = 1'b0;
    fifo_full          = 1'b0;
    junk               = '0;
    holding            = 1'b0;
    first_cyc          = 1'b0;
    repeat (2) @(posedge clk);
    reset_release();

    // Streaming from reset, then a full FIFO parks line 0x40.
    repeat (4) cyc(1, 0, 0, 32'h0);
    repeat (3) cyc(1, 1, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0);
    // Redirect from REQ to 0x128.
    cyc(1, 0, 1, 32'h0000_0128);
    repeat (2) cyc(1, 0, 0, 32'h0);
    // Five-cycle miss at 0x80.
    cyc(1, 0, 1, 32'h0000_0070);
    cyc(1, 0, 0, 32'h0);
    repeat (5) cyc(0, 0, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0);
    // Redirect while parked, then a newer redirect while REDIR has a hit.
    cyc(1, 1, 0, 32'h0);
    cyc(0, 1, 1, 32'h0000_0300);
    cyc(1, 0, 1, 32'h0000_0204);
    repeat (2) cyc(1, 0, 0, 32'h0);
    // Address wrap, then reset while parked.
    cyc(1, 0, 1, 32'hFFFF_FFF0);
    repeat (2) cyc(1, 0, 0, 32'h0);
    repeat (2) cyc(1, 1, 0, 32'h0);
    reset_assert();
    reset_release();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset_assert();
        reset_release();
      end else begin
        tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)) : $urandom;
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, tgt);
      end
    end
    cyc(1, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
